// File: rtl/pc_sequencer_if.sv
// Fetch-stage control and status bundle for the program-counter sequencer.
// The decode/branch logic drives the master side and the sequencer implements the slave side.
interface pc_sequencer_if #(
   parameter int WIDTH = 16
);

   logic             stall;
   logic             jumpEN;
   logic [WIDTH-1:0] immediate;
   logic             jalEN;
   logic [WIDTH-1:0] RTarget;
   logic             retEN;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pcNext;
   logic [WIDTH-1:0] Rlink;
   logic             rasEmpty;
   logic             rasFull;
   logic             rasUnderflow;

   modport master (
      output stall, jumpEN, immediate, jalEN, RTarget, retEN,
      input  pc, pcNext, Rlink, rasEmpty, rasFull, rasUnderflow
   );

   modport slave (
      input  stall, jumpEN, immediate, jalEN, RTarget, retEN,
      output pc, pcNext, Rlink, rasEmpty, rasFull, rasUnderflow
   );

endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with a circular return-address stack.
// Each cycle it selects increment, relative branch, jump-and-link or return.
module pc_sequencer #(
   parameter int               WIDTH     = 16,
   parameter int               RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   localparam int             PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int             CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_link;
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_empty;
   logic             r_full;
   logic             r_underflow;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];

   logic [WIDTH-1:0] w_pcInc;
   logic [PTR_W-1:0] w_topIdx;
   logic [WIDTH-1:0] w_top;
   logic             w_push;
   logic             w_retReq;
   logic             w_pop;
   logic             w_underflowEvt;
   logic [WIDTH-1:0] w_pcNext;
   logic [PTR_W-1:0] w_ptrNext;
   logic [CNT_W-1:0] w_countNext;

   assign w_pcInc        = r_pc + WIDTH'(1);
   assign w_topIdx       = r_ptr - PTR_W'(1);
   assign w_top          = r_ras[w_topIdx];
   assign w_push         = !bus.stall && bus.jalEN;
   assign w_retReq       = !bus.stall && !bus.jalEN && bus.retEN;
   assign w_pop          = w_retReq && !r_empty;
   assign w_underflowEvt = w_retReq && r_empty;

   // Next-PC selection follows stall > jal > ret > jump > increment.
   always_comb begin
      w_pcNext = w_pcInc;
      if (bus.stall) begin
         w_pcNext = r_pc;
      end else if (bus.jalEN) begin
         w_pcNext = bus.RTarget;
      end else if (bus.retEN) begin
         w_pcNext = r_empty ? w_pcInc : w_top;
      end else if (bus.jumpEN) begin
         w_pcNext = r_pc + bus.immediate;
      end
   end

   // A push into a full stack advances the pointer but leaves the count
   // saturated, so the oldest return address is silently overwritten.
   always_comb begin
      w_ptrNext   = r_ptr;
      w_countNext = r_count;
      if (w_push) begin
         w_ptrNext = r_ptr + PTR_W'(1);
         if (!r_full) begin
            w_countNext = r_count + CNT_W'(1);
         end
      end else if (w_pop) begin
         w_ptrNext   = w_topIdx;
         w_countNext = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_link      <= '0;
         r_ptr       <= '0;
         r_count     <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!bus.stall) begin
         r_pc    <= w_pcNext;
         r_ptr   <= w_ptrNext;
         r_count <= w_countNext;
         r_empty <= (w_countNext == '0);
         r_full  <= (w_countNext == FULL_CNT);
         if (w_push) begin
            r_link <= w_pcInc;
         end
         if (w_underflowEvt) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Stack storage needs no reset; the valid count decides what is live.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_ras[r_ptr] <= w_pcInc;
      end
   end

   assign bus.pc           = r_pc;
   assign bus.pcNext       = w_pcNext;
   assign bus.Rlink        = r_link;
   assign bus.rasEmpty     = r_empty;
   assign bus.rasFull      = r_full;
   assign bus.rasUnderflow = r_underflow;

endmodule
